// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller. Loads that miss refill a whole line word by word. Stores
// write through to backing memory, and they update the cached copy only
// when the line is already present.
// Optional feature macro: DCACHE_STATS_EN adds the read hit and read miss
// counters o_HitCount and o_MissCount.
module dcache_ctrl #(
    parameter int BUS_WIDTH      = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic [BUS_WIDTH-1:0] i_Addr,
    input  logic [BUS_WIDTH-1:0] i_WData,
    output logic [BUS_WIDTH-1:0] o_RData,
    output logic                 o_Stall,
    output logic                 o_MemReq,
    output logic                 o_MemWe,
    output logic [BUS_WIDTH-1:0] o_MemAddr,
    output logic [BUS_WIDTH-1:0] o_MemWData,
    input  logic                 i_MemAck,
    input  logic [BUS_WIDTH-1:0] i_MemRData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          o_HitCount,
    output logic [31:0]          o_MissCount
`endif
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = OFF_W + IDX_W + 2;
    localparam int TAG_W   = BUS_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                 state_reg, state_next;
    logic [OFF_W-1:0]       cnt_reg;
    logic [BUS_WIDTH-3:0]   addr_reg;    // latched word address (byte bits dropped)
    logic [BUS_WIDTH-1:0]   wdata_reg;
    logic [LINES-1:0]       valid_reg;

    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [BUS_WIDTH-1:0]   data_mem [LINES*WORDS_PER_LINE];

    // Address fields of the incoming request and of the latched request.
    logic [OFF_W-1:0]       req_off, lat_off;
    logic [IDX_W-1:0]       req_idx, lat_idx;
    logic [TAG_W-1:0]       req_tag, lat_tag;
    logic                   req_hit, lat_hit;

    // Control strobes from the FSM to the datapath.
    logic                   start_refill, start_write;
    logic                   fill_we, fill_last, wr_update, count_hit;

    assign req_off = i_Addr[OFF_W+1:2];
    assign req_idx = i_Addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag = i_Addr[BUS_WIDTH-1:TAG_LSB];
    assign lat_off = addr_reg[OFF_W-1:0];
    assign lat_idx = addr_reg[OFF_W+IDX_W-1:OFF_W];
    assign lat_tag = addr_reg[BUS_WIDTH-3:OFF_W+IDX_W];

    assign req_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lat_hit = valid_reg[lat_idx] && (tag_mem[lat_idx] == lat_tag);

    // Byte-lane bits of the address never select anything.
    logic unused_byte_bits;
    assign unused_byte_bits = ^i_Addr[1:0];

    // State register. On reset, any request in flight drops straight away.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic, memory-side outputs and datapath strobes.
    always_comb begin
        state_next   = state_reg;
        o_Stall      = 1'b0;
        o_MemReq     = 1'b0;
        o_MemWe      = 1'b0;
        o_MemAddr    = '0;
        o_MemWData   = '0;
        o_RData      = '0;
        start_refill = 1'b0;
        start_write  = 1'b0;
        fill_we      = 1'b0;
        fill_last    = 1'b0;
        wr_update    = 1'b0;
        count_hit    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_MemWrite) begin
                    // A store takes priority when both strobes are high.
                    o_Stall     = 1'b1;
                    start_write = 1'b1;
                    state_next  = WRITE;
                end else if (i_MemRead) begin
                    if (req_hit) begin
                        o_RData   = data_mem[{req_idx, req_off}];
                        count_hit = 1'b1;
                    end else begin
                        o_Stall      = 1'b1;
                        start_refill = 1'b1;
                        state_next   = REFILL;
                    end
                end
            end
            REFILL: begin
                o_Stall   = 1'b1;
                o_MemReq  = 1'b1;
                o_MemAddr = {addr_reg[BUS_WIDTH-3:OFF_W], cnt_reg, 2'b00};
                if (i_MemAck) begin
                    fill_we = 1'b1;
                    if (&cnt_reg) begin
                        fill_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                o_MemReq   = 1'b1;
                o_MemWe    = 1'b1;
                o_MemAddr  = {addr_reg, 2'b00};
                o_MemWData = wdata_reg;
                // The core advances on the same edge that accepts the store.
                o_Stall    = ~i_MemAck;
                if (i_MemAck) begin
                    wr_update  = lat_hit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, refill word counter and per-line valid bits.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (start_refill || start_write) begin
                addr_reg <= i_Addr[BUS_WIDTH-1:2];
            end
            if (start_write) begin
                wdata_reg <= i_WData;
            end
            if (start_refill) begin
                // The victim line is invalid until its refill completes.
                cnt_reg            <= '0;
                valid_reg[req_idx] <= 1'b0;
            end
            if (fill_we) begin
                cnt_reg <= cnt_reg + OFF_W'(1);
            end
            if (fill_last) begin
                valid_reg[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage writes: refill words, refill tag, store hits.
    always_ff @(posedge i_Clk) begin
        if (fill_we) begin
            data_mem[{lat_idx, cnt_reg}] <= i_MemRData;
        end
        if (fill_last) begin
            tag_mem[lat_idx] <= lat_tag;
        end
        if (wr_update) begin
            data_mem[{lat_idx, lat_off}] <= wdata_reg;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_reg, miss_count_reg;

    // Read hit and miss counters. Stores are not counted, and both counters wrap.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (count_hit)    hit_count_reg  <= hit_count_reg + 32'd1;
            if (start_refill) miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign o_HitCount  = hit_count_reg;
    assign o_MissCount = miss_count_reg;
`else
    logic unused_stats;
    assign unused_stats = count_hit;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized check of dcache_ctrl against a line-level
// model. The model holds a sparse backing memory and the valid/tag of each
// cache line. Directed test-plan cases run first, then random traffic,
// then a reset issued during a refill.
module tb_dcache_ctrl;

    localparam int BW    = 32;
    localparam int LINES = 16;
    localparam int WPL   = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [BW-1:0] addr, wdata, rdata;
    logic          stall, mem_req, mem_we;
    logic [BW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    dcache_ctrl #(.BUS_WIDTH(BW), .LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_MemRead  (mem_read),
        .i_MemWrite (mem_write),
        .i_Addr     (addr),
        .i_WData    (wdata),
        .o_RData    (rdata),
        .o_Stall    (stall),
        .o_MemReq   (mem_req),
        .o_MemWe    (mem_we),
        .o_MemAddr  (mem_addr),
        .o_MemWData (mem_wdata),
        .i_MemAck   (mem_ack),
        .i_MemRData (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .o_HitCount (hit_count),
        .o_MissCount(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit [31:0] mem [bit [31:0]];
    bit        ref_valid [LINES];
    bit [31:0] ref_tag   [LINES];
    int        exp_hits, exp_miss;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'h0000} ^ 32'h3C5A_96E1 ^ a;
    endfunction

    function automatic int line_idx(input bit [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    function automatic bit [31:0] line_tag(input bit [31:0] a);
        return a / (LINE_BYTES * LINES);
    endfunction

    // One core access. Called just after a falling edge; returns one
    // falling edge after the access, having checked one idle cycle.
    task automatic do_op(input bit rd, input bit wr, input bit [31:0] a_in,
                         input bit [31:0] wd, input int waits);
        bit [31:0] a    = a_in & ~32'h3;
        bit [31:0] base = a & ~32'(LINE_BYTES - 1);
        int        idx  = line_idx(a);
        bit        hit  = ref_valid[idx] && (ref_tag[idx] == line_tag(a));
        bit        is_wr = wr;
        int exp_stall, exp_reqs;
        int stalls = 0, reqs = 0, acks = 0, wcnt = 0;
        bit done = 1'b0;

        if (is_wr) begin
            exp_stall = 1 + waits;
            exp_reqs  = 1 + waits;
        end else if (hit) begin
            exp_stall = 0;
            exp_reqs  = 0;
        end else begin
            exp_stall = 1 + WPL * (1 + waits);
            exp_reqs  = WPL * (1 + waits);
        end

        mem_read  = rd;
        mem_write = wr;
        addr      = a_in;
        wdata     = wd;
        mem_ack   = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                reqs++;
                if (is_wr) begin
                    check("wr_we", 32'(mem_we), 32'd1);
                    check("wr_addr", mem_addr, a);
                    check("wr_data", mem_wdata, wd);
                end else begin
                    check("rf_we", 32'(mem_we), 32'd0);
                    check("rf_addr", mem_addr, base + 32'(4 * acks));
                end
                if (wcnt < waits) begin
                    wcnt++;
                end else begin
                    wcnt      = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    acks++;
                end
            end
            #1;
            if (stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (rd && !wr) check("rdata", rdata, mem_rd(a));
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("timeout", 32'(done), 32'd1);
        check("stalls", 32'(stalls), 32'(exp_stall));
        check("req_cycles", 32'(reqs), 32'(exp_reqs));

        // Model update: write-through, no allocate on store miss.
        if (is_wr) begin
            mem[a] = wd;
        end else begin
            exp_hits++;
            if (!hit) begin
                exp_miss++;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = line_tag(a);
            end
        end
        $display("op rd=%0d wr=%0d addr=%h wdata=%h waits=%0d hit=%0d stalls=%0d",
                 rd, wr, a_in, wd, waits, hit, stalls);

        // Idle cycle: no stall, no request, no load data; a stray ack is ignored.
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
        check("idle_rdata", rdata, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hits"}, hit_count, 32'(exp_hits));
        check({tag, "_miss"}, miss_count, 32'(exp_miss));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_hits  = 0;
        exp_miss  = 0;
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        mem[32'h100] = 32'hA0;
        mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2;
        mem[32'h10C] = 32'hA3;

        @(negedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check_stats("rst");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan.
        do_op(1'b1, 1'b0, 32'h100, 32'h0, 0);
        do_op(1'b1, 1'b0, 32'h104, 32'h0, 0);
        do_op(1'b1, 1'b0, 32'h10C, 32'h0, 0);
        do_op(1'b0, 1'b1, 32'h108, 32'hDEAD, 2);
        do_op(1'b1, 1'b0, 32'h108, 32'h0, 0);
        do_op(1'b0, 1'b1, 32'h500, 32'h1234_5678, 0);
        do_op(1'b1, 1'b0, 32'h500, 32'h0, 1);
        do_op(1'b1, 1'b0, 32'h140, 32'h0, 0);
        do_op(1'b1, 1'b0, 32'h100, 32'h0, 0);
        do_op(1'b1, 1'b1, 32'h104, 32'hBEEF_0001, 0);
        do_op(1'b1, 1'b0, 32'h104, 32'h0, 0);

        // Random traffic over a small address window for frequent conflicts.
        for (int n = 0; n < 250; n++) begin
            int  kind = $urandom_range(0, 9);
            bit  rd   = (kind < 6) || (kind == 9);
            bit  wr   = (kind >= 6);
            do_op(rd, wr, 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 2));
        end
        check_stats("run");

        // Reset after the second refill ack of a miss on 0x310.
        mem_read = 1'b1;
        addr     = 32'h310;
        #1;
        check("abort_miss_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            mem_ack   = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        mem_ack = 1'b0;
        check("abort_req_before", 32'(mem_req), 32'd1);
        check("abort_addr_before", mem_addr, 32'h318);
        rst = 1'b1;
        #1;
        check("abort_req_after", 32'(mem_req), 32'd0);
        check("abort_addr_after", mem_addr, 32'd0);
        mem_read = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        #1;
        check_stats("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("op reset during refill of 310");

        do_op(1'b1, 1'b0, 32'h200, 32'h0, 0);
        do_op(1'b1, 1'b0, 32'h310, 32'h0, 0);
        do_op(1'b1, 1'b0, 32'h314, 32'h0, 0);
        check_stats("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
